// File: rtl/rvfi_commit_checker_rv32imc_pkg.sv
// Shared types, check IDs and helpers for the RVFI commit checker.
// One channel slice and the architectural shadow state passed along the chain.
package rvfi_chk_pkg;
  localparam int NRET = 8;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [7:0] CHK_ORDER = 8'h01;
  localparam logic [7:0] CHK_PC    = 8'h02;
  localparam logic [7:0] CHK_RS1   = 8'h03;
  localparam logic [7:0] CHK_RS2   = 8'h04;
  localparam logic [7:0] CHK_X0    = 8'h05;
  localparam logic [7:0] CHK_MASK  = 8'h06;
  localparam logic [7:0] CHK_MPC   = 8'h07;
  localparam logic [7:0] CHK_TRAP  = 8'h08;

  typedef logic [31:0][XLEN-1:0] regfile_t;

  typedef struct packed {
    logic            valid;
    logic [63:0]     order;
    logic            trap;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [3:0]      rmask;
    logic [3:0]      wmask;
  } chan_t;

  typedef struct packed {
    logic [63:0]     exp_order;
    logic            pc_known;
    logic [XLEN-1:0] last_pc;
    logic [31:0]     vld;
    regfile_t        regs;
  } chk_state_t;

  function automatic logic [15:0] pack_err(
    input logic [2:0] chan,
    input logic [7:0] id
  );
    return {4'h8, 1'b0, chan, id};
  endfunction

  function automatic logic mask_ok(input logic [3:0] m);
    unique case (m)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h8,
      4'h3, 4'hC, 4'hF: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/rvfi_commit_checker_rv32imc_if.sv
// RVFI retirement bus, NRET channels packed side by side.
interface rvfi_commit_checker_rv32imc_if
  import rvfi_chk_pkg::*;
  ;
  logic [NRET-1:0]      rvfi_valid;
  logic [64*NRET-1:0]   rvfi_order;
  logic [ILEN*NRET-1:0] rvfi_insn;
  logic [NRET-1:0]      rvfi_trap;
  logic [NRET-1:0]      rvfi_halt;
  logic [NRET-1:0]      rvfi_intr;
  logic [2*NRET-1:0]    rvfi_mode;
  logic [5*NRET-1:0]    rvfi_rs1_addr;
  logic [5*NRET-1:0]    rvfi_rs2_addr;
  logic [XLEN*NRET-1:0] rvfi_rs1_rdata;
  logic [XLEN*NRET-1:0] rvfi_rs2_rdata;
  logic [5*NRET-1:0]    rvfi_rd_addr;
  logic [XLEN*NRET-1:0] rvfi_rd_wdata;
  logic [XLEN*NRET-1:0] rvfi_pc_rdata;
  logic [XLEN*NRET-1:0] rvfi_pc_wdata;
  logic [XLEN*NRET-1:0] rvfi_mem_addr;
  logic [4*NRET-1:0]    rvfi_mem_rmask;
  logic [4*NRET-1:0]    rvfi_mem_wmask;
  logic [XLEN*NRET-1:0] rvfi_mem_rdata;
  logic [XLEN*NRET-1:0] rvfi_mem_wdata;
  logic [NRET-1:0]      rvfi_mem_extamo;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap,
    output rvfi_halt, rvfi_intr, rvfi_mode,
    output rvfi_rs1_addr, rvfi_rs2_addr,
    output rvfi_rs1_rdata, rvfi_rs2_rdata,
    output rvfi_rd_addr, rvfi_rd_wdata,
    output rvfi_pc_rdata, rvfi_pc_wdata,
    output rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
    output rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_extamo
  );

  modport slave (
    input rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap,
    input rvfi_halt, rvfi_intr, rvfi_mode,
    input rvfi_rs1_addr, rvfi_rs2_addr,
    input rvfi_rs1_rdata, rvfi_rs2_rdata,
    input rvfi_rd_addr, rvfi_rd_wdata,
    input rvfi_pc_rdata, rvfi_pc_wdata,
    input rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
    input rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_extamo
  );
endinterface

// File: rtl/rvfi_commit_checker_rv32imc_channel.sv
// Combinational checker for one retirement slot; forwards updated state.
module rvfi_chk_channel
  import rvfi_chk_pkg::*;
(
  input  chan_t      i_ch,
  input  chk_state_t i_st,
  output chk_state_t o_st,
  output logic       o_err,
  output logic [7:0] o_id
);
  logic w_rs1_bad;
  logic w_rs2_bad;
  logic w_mask_bad;

  assign w_rs1_bad = (i_ch.rs1_addr != 5'd0) &&
                     i_st.vld[i_ch.rs1_addr] &&
                     (i_ch.rs1_rdata != i_st.regs[i_ch.rs1_addr]);
  assign w_rs2_bad = (i_ch.rs2_addr != 5'd0) &&
                     i_st.vld[i_ch.rs2_addr] &&
                     (i_ch.rs2_rdata != i_st.regs[i_ch.rs2_addr]);
  assign w_mask_bad = ((i_ch.rmask != 4'd0) && (i_ch.wmask != 4'd0)) ||
                      !mask_ok(i_ch.rmask) || !mask_ok(i_ch.wmask);

  always_comb begin
    o_st  = i_st;
    o_err = 1'b0;
    o_id  = 8'd0;
    if (i_ch.valid) begin
      // Lowest check ID wins within a slot.
      o_err = 1'b1;
      if (i_ch.order != i_st.exp_order)                     o_id = CHK_ORDER;
      else if (i_st.pc_known && i_ch.pc_rdata != i_st.last_pc) o_id = CHK_PC;
      else if (w_rs1_bad)                                   o_id = CHK_RS1;
      else if (w_rs2_bad)                                   o_id = CHK_RS2;
      else if (i_ch.rd_addr == 5'd0 && i_ch.rd_wdata != '0 &&
               !i_ch.trap)                                  o_id = CHK_X0;
      else if (w_mask_bad)                                  o_id = CHK_MASK;
      else if (i_ch.pc_wdata[0])                            o_id = CHK_MPC;
      else if (i_ch.trap)                                   o_id = CHK_TRAP;
      else                                                  o_err = 1'b0;

      o_st.exp_order = i_ch.order + 64'd1;
      o_st.pc_known  = 1'b1;
      o_st.last_pc   = i_ch.pc_wdata;
      if (i_ch.rs1_addr != 5'd0 && !i_st.vld[i_ch.rs1_addr]) begin
        o_st.regs[i_ch.rs1_addr] = i_ch.rs1_rdata;
        o_st.vld[i_ch.rs1_addr]  = 1'b1;
      end
      if (i_ch.rs2_addr != 5'd0 && !i_st.vld[i_ch.rs2_addr]) begin
        o_st.regs[i_ch.rs2_addr] = i_ch.rs2_rdata;
        o_st.vld[i_ch.rs2_addr]  = 1'b1;
      end
      if (i_ch.rd_addr != 5'd0) begin
        o_st.regs[i_ch.rd_addr] = i_ch.rd_wdata;
        o_st.vld[i_ch.rd_addr]  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rvfi_commit_checker_rv32imc.sv
// RVFI retirement consistency checker: chained per-slot checks,
// shadow register file and a sticky first-error latch.
module rvfi_commit_checker_rv32imc
  import rvfi_chk_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  rvfi_commit_checker_rv32imc_if.slave  rvfi,
  output logic [15:0]                   errcode
);
  chk_state_t  r_st;
  logic        r_frozen;
  logic [15:0] r_err;

  chk_state_t  w_st [NRET+1];
  logic        w_err [NRET];
  logic [7:0]  w_id [NRET];
  logic        w_hit;
  logic [15:0] w_code;
  logic        w_unused;

  assign w_st[0] = r_st;

  for (genvar c = 0; c < NRET; c++) begin : g_ch
    chan_t w_c;
    always_comb begin
      w_c.valid     = rvfi.rvfi_valid[c];
      w_c.order     = rvfi.rvfi_order[c*64 +: 64];
      w_c.trap      = rvfi.rvfi_trap[c];
      w_c.rs1_addr  = rvfi.rvfi_rs1_addr[c*5 +: 5];
      w_c.rs2_addr  = rvfi.rvfi_rs2_addr[c*5 +: 5];
      w_c.rd_addr   = rvfi.rvfi_rd_addr[c*5 +: 5];
      w_c.rs1_rdata = rvfi.rvfi_rs1_rdata[c*XLEN +: XLEN];
      w_c.rs2_rdata = rvfi.rvfi_rs2_rdata[c*XLEN +: XLEN];
      w_c.rd_wdata  = rvfi.rvfi_rd_wdata[c*XLEN +: XLEN];
      w_c.pc_rdata  = rvfi.rvfi_pc_rdata[c*XLEN +: XLEN];
      w_c.pc_wdata  = rvfi.rvfi_pc_wdata[c*XLEN +: XLEN];
      w_c.rmask     = rvfi.rvfi_mem_rmask[c*4 +: 4];
      w_c.wmask     = rvfi.rvfi_mem_wmask[c*4 +: 4];
    end

    rvfi_chk_channel u_ch (
      .i_ch  (w_c),
      .i_st  (w_st[c]),
      .o_st  (w_st[c+1]),
      .o_err (w_err[c]),
      .o_id  (w_id[c])
    );
  end

  // Scan downwards so the lowest failing slot is the one kept.
  always_comb begin
    w_hit  = 1'b0;
    w_code = 16'd0;
    for (int c = NRET - 1; c >= 0; c--) begin
      if (w_err[c]) begin
        w_hit  = 1'b1;
        w_code = pack_err(3'(c), w_id[c]);
      end
    end
  end

  assign w_unused = ^{rvfi.rvfi_insn, rvfi.rvfi_intr, rvfi.rvfi_mode,
                      rvfi.rvfi_mem_addr, rvfi.rvfi_mem_rdata,
                      rvfi.rvfi_mem_wdata, rvfi.rvfi_mem_extamo};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_st     <= '0;
      r_frozen <= 1'b0;
      r_err    <= 16'd0;
    end else if (!r_frozen) begin
      if (|rvfi.rvfi_halt) begin
        r_frozen <= 1'b1;
      end else begin
        r_st <= w_st[NRET];
        if (r_err == 16'd0 && w_hit) r_err <= w_code;
      end
    end
  end

  assign errcode = r_err;
endmodule

// File: tb/tb_rvfi_commit_checker_rv32imc.sv
// Scoreboard bench: stimulus queues expected errcode per edge,
// monitor compares one cycle later.
module tb_rvfi_commit_checker_rv32imc;
  import rvfi_chk_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] errcode;
  logic [15:0] sb [$];
  int          checks = 0;
  int          errors = 0;

  rvfi_commit_checker_rv32imc_if rvfi ();

  rvfi_commit_checker_rv32imc dut (
    .clock   (clock),
    .reset   (reset),
    .rvfi    (rvfi),
    .errcode (errcode)
  );

  always #5 clock = ~clock;

  task automatic clr();
    rvfi.rvfi_valid      = '0;
    rvfi.rvfi_order      = '0;
    rvfi.rvfi_insn       = '0;
    rvfi.rvfi_trap       = '0;
    rvfi.rvfi_halt       = '0;
    rvfi.rvfi_intr       = '0;
    rvfi.rvfi_mode       = '0;
    rvfi.rvfi_rs1_addr   = '0;
    rvfi.rvfi_rs2_addr   = '0;
    rvfi.rvfi_rs1_rdata  = '0;
    rvfi.rvfi_rs2_rdata  = '0;
    rvfi.rvfi_rd_addr    = '0;
    rvfi.rvfi_rd_wdata   = '0;
    rvfi.rvfi_pc_rdata   = '0;
    rvfi.rvfi_pc_wdata   = '0;
    rvfi.rvfi_mem_addr   = '0;
    rvfi.rvfi_mem_rmask  = '0;
    rvfi.rvfi_mem_wmask  = '0;
    rvfi.rvfi_mem_rdata  = '0;
    rvfi.rvfi_mem_wdata  = '0;
    rvfi.rvfi_mem_extamo = '0;
  endtask

  task automatic ret(input int c, input logic [63:0] ord,
                     input logic [31:0] pcr, input logic [31:0] pcw,
                     input logic [4:0] rd, input logic [31:0] wd);
    rvfi.rvfi_valid[c]            = 1'b1;
    rvfi.rvfi_order[c*64 +: 64]   = ord;
    rvfi.rvfi_pc_rdata[c*32 +: 32] = pcr;
    rvfi.rvfi_pc_wdata[c*32 +: 32] = pcw;
    rvfi.rvfi_rd_addr[c*5 +: 5]   = rd;
    rvfi.rvfi_rd_wdata[c*32 +: 32] = wd;
  endtask

  task automatic rs(input int c, input logic [4:0] a1, input logic [31:0] d1,
                    input logic [4:0] a2, input logic [31:0] d2);
    rvfi.rvfi_rs1_addr[c*5 +: 5]    = a1;
    rvfi.rvfi_rs1_rdata[c*32 +: 32] = d1;
    rvfi.rvfi_rs2_addr[c*5 +: 5]    = a2;
    rvfi.rvfi_rs2_rdata[c*32 +: 32] = d2;
  endtask

  task automatic mem(input int c, input logic [3:0] rm, input logic [3:0] wm);
    rvfi.rvfi_mem_rmask[c*4 +: 4] = rm;
    rvfi.rvfi_mem_wmask[c*4 +: 4] = wm;
  endtask

  // Inputs set before the call are sampled at the next rising edge.
  task automatic go(input logic [15:0] e);
    sb.push_back(e);
    @(negedge clock);
    clr();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    go(16'h0000);
    reset = 1'b0;
  endtask

  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (errcode !== e) begin
          errors++;
          $display("FAIL errcode check %0d: got 0x%04h expected 0x%04h",
                   checks, errcode, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    clr();
    @(negedge clock);

    // clean two-slot retire with same-cycle x1 forwarding
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd1, 32'd5);
    ret(1, 1, 32'h4, 32'h8, 5'd0, 32'd0);
    rs(1, 5'd1, 32'd5, 5'd0, 32'd0);
    go(16'h0000);
    go(16'h0000);

    // order skip on slot 2, then held through later commits
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd0, 32'd0);
    go(16'h0000);
    ret(2, 5, 32'h4, 32'h8, 5'd0, 32'd0);
    go(16'h8201);
    ret(0, 6, 32'h8, 32'hC, 5'd0, 32'd0);
    go(16'h8201);
    ret(0, 99, 32'h0, 32'h3, 5'd0, 32'd0);
    go(16'h8201);

    // rs2 mismatch against same-cycle write
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd3, 32'd7);
    ret(1, 1, 32'h4, 32'h8, 5'd0, 32'd0);
    rs(1, 5'd0, 32'd0, 5'd3, 32'd8);
    go(16'h8104);

    // pc discontinuity
    do_reset();
    ret(0, 0, 32'h0, 32'h10, 5'd0, 32'd0);
    go(16'h0000);
    ret(0, 1, 32'h14, 32'h18, 5'd0, 32'd0);
    go(16'h8002);

    // bad masks, and a legal full-word mask
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd0, 32'd0);
    mem(0, 4'b0110, 4'h0);
    go(16'h8006);
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd0, 32'd0);
    mem(0, 4'h1, 4'h1);
    go(16'h8006);
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd0, 32'd0);
    mem(0, 4'hF, 4'h0);
    go(16'h0000);

    // invalid slot between valid ones carries garbage
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd0, 32'd0);
    rvfi.rvfi_order[64 +: 64] = 64'd77;
    rvfi.rvfi_trap[1] = 1'b1;
    ret(2, 1, 32'h4, 32'h8, 5'd0, 32'd0);
    go(16'h0000);

    // x0 write, trap suppresses it, misaligned pc, x0 read
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd0, 32'd5);
    go(16'h8005);
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd0, 32'd5);
    rvfi.rvfi_trap[0] = 1'b1;
    go(16'h8008);
    do_reset();
    ret(0, 0, 32'h0, 32'h5, 5'd0, 32'd0);
    go(16'h8007);
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd0, 32'd0);
    rs(0, 5'd0, 32'h55, 5'd0, 32'h66);
    go(16'h0000);

    // shadow learned from a first read, then contradicted
    do_reset();
    ret(0, 0, 32'h0, 32'h4, 5'd0, 32'd0);
    rs(0, 5'd4, 32'd9, 5'd0, 32'd0);
    go(16'h0000);
    ret(0, 1, 32'h4, 32'h8, 5'd0, 32'd0);
    rs(0, 5'd4, 32'd10, 5'd0, 32'd0);
    go(16'h8003);

    // priority: lower slot over lower ID, lower ID within a slot
    do_reset();
    ret(1, 2, 32'h0, 32'h4, 5'd0, 32'd0);
    ret(3, 3, 32'h4, 32'h8, 5'd0, 32'd0);
    rvfi.rvfi_trap[3] = 1'b1;
    go(16'h8101);
    do_reset();
    ret(0, 1, 32'h0, 32'h5, 5'd0, 32'd0);
    rvfi.rvfi_trap[0] = 1'b1;
    go(16'h8001);

    // halt freezes checking until reset
    do_reset();
    rvfi.rvfi_halt = '1;
    go(16'h0000);
    rvfi.rvfi_halt = '1;
    ret(0, 9, 32'h0, 32'h4, 5'd0, 32'd0);
    go(16'h0000);
    rvfi.rvfi_halt = '1;
    ret(0, 9, 32'h0, 32'h3, 5'd0, 32'd0);
    go(16'h0000);
    do_reset();
    ret(0, 4, 32'h0, 32'h4, 5'd0, 32'd0);
    go(16'h8001);

    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
